output_credit_lock_ctrl: RTL and testbench
==========================================

Name: output_credit_lock_ctrl

Overview:
- Per-output-port controller that sits beside switch_control in each router.
- Tracks downstream buffer credits for each of the M output ports. Drives the per-output enable vector that switch_control consumes as i_en.
- Enforces wormhole packet locking: once a multi-flit packet's head wins an output, only that input may use the output until its tail flit is granted.
- All state is registered and updated on grants returned by switch_control and on credit-return pulses from downstream routers.

Parameters:
- N, `N, number of local input units (requesters).
- M, `M, number of output ports.
- CREDITS, 4, downstream buffer depth per output, in flits; reset credit count.
- CW, 3, credit counter width; must satisfy 2**CW > CREDITS.

Ports:
- clk  input  1  router clock
- reset_n  input  1  asynchronous active-low reset
- ce  input  1  clock enable; all state updates gated by ce
- i_output_grant  input  [0:M-1][0:N-1]  per-output one-hot grant from switch_control
- i_head  input  [0:N-1]  front flit of input n is a head flit
- i_tail  input  [0:N-1]  front flit of input n is a tail flit; head&tail means single-flit packet
- i_credit_return  input  [0:M-1]  one-cycle pulse: downstream freed one slot on output m
- o_en  output  [0:M-1]  output m may accept a flit; to switch_control i_en
- o_req_mask  output  [0:N-1][0:M-1]  input n may request output m; ANDed with requests upstream
- o_lock_valid  output  [0:M-1]  output m is locked to a packet
- o_lock_owner  output  [0:M-1][0:N-1]  one-hot owner of output m; zero when unlocked
- o_credit_count  output  [0:M-1][CW-1:0]  current credit count, for debug
- o_error  output  [0:M-1]  sticky protocol error flag per output

Behaviour:
- Reset is asynchronous and active-low: reset_n low immediately forces every output port's state to its reset value, independent of clk and ce.
  - Credit counts = CREDITS.
  - Lock FSMs in IDLE; owners = 0; o_error = 0.
  - Hence o_en = all ones, o_req_mask = all ones, o_lock_valid = 0, o_lock_owner = 0.
- A reset asserted mid-packet drops the lock and restores full credits; no partial state survives.
- ce low: all registers hold, including credit counts. Downstream holds credit pulses while ce is low (router-wide ce), so no return is lost.
- Grant event g[m] = OR of i_output_grant[m]; evaluated only with ce high.
- Credit counter per output, updated at the clock edge:
  - g only: count-1.
  - return only: count+1.
  - Both together: unchanged.
  - g with count==0: count stays 0, o_error[m] set (underflow).
  - Return without g at count==CREDITS: count stays CREDITS, o_error[m] set (overflow).
- o_en[m] = (count[m] != 0). Combinational from the register only; a credit return is visible on o_en one cycle later.
- Lock FSM per output, states IDLE and LOCKED:
  - IDLE, grant to input n with i_head[n] & !i_tail[n]: go to LOCKED, owner = one-hot n.
  - IDLE, grant to input n with i_head[n] & i_tail[n]: stay IDLE (single-flit packet).
  - IDLE, grant to input n with !i_head[n]: stay IDLE, set o_error[m].
  - LOCKED, grant to the owner with i_tail[owner]: go to IDLE, owner = 0, in the same edge.
  - LOCKED, grant to the owner without tail: stay LOCKED (body flit).
  - LOCKED, grant to a non-owner: state unchanged, o_error[m] set. The credit is still consumed, since the flit physically moved.
  - Lock release and a new head grant cannot occur in the same cycle on one output; a new head can win from the next cycle.
- o_req_mask[n][m] = !lock_valid[m] | owner[m][n]. Combinational from registers.
- i_output_grant[m] not one-hot (more than one bit set): set o_error[m], consume one credit, leave the FSM unchanged.
- o_error bits clear only on reset.

Optional Feature:
- CREDIT_BYPASS_EN defined: o_en[m] = (count[m] != 0) | i_credit_return[m]. An arriving credit enables the output in the same cycle; a grant on a zero count with a simultaneous return is legal and leaves count at 0.
- CREDIT_BYPASS_EN undefined: o_en is purely register-based as described under Behaviour.

Test Plan:
- Reset, then idle for 3 cycles -> o_en=all 1, o_credit_count=4 on every port, o_req_mask=all 1, o_error=0.
- 4 single-flit grants on output 0 from input 1, no returns -> count 3,2,1,0; o_en[0]=0 after the 4th; 1 return -> count=1 and o_en[0]=1 the following cycle.
- Head on input 2 granted output 3, then 2 body flits, then tail -> o_lock_valid[3]=1 with owner=00100 for 3 cycles; o_req_mask[n][3]=0 for n!=2; lock clears on the tail edge.
- Simultaneous grant and return on output 1 at count 2 -> count stays 2, no error.
- Grant on output 4 at count 0 -> o_error[4]=1 and sticky, count stays 0; return at count 4 on output 2 -> o_error[2]=1, count stays 4.
- ce held low for 5 cycles with grants applied -> no state change; reset_n pulsed low mid-packet -> lock dropped, counts return to 4 immediately.

Source files
------------

// File: rtl/output_credit_lock_ctrl.sv
// output_credit_lock_ctrl
// Per-output credit tracking and wormhole lock control that sits beside
// switch_control. Counts downstream buffer credits per output, drives the
// per-output enable vector, and locks an output to the input whose multi-flit
// packet head won it until that packet's tail is granted.
//
// Optional feature macro: CREDIT_BYPASS_EN
//   defined   : an arriving credit return enables its output in the same cycle
//   undefined : o_en depends on the registered credit count only
//
// Ports
//   clk              router clock
//   reset_n          asynchronous active-low reset
//   ce               clock enable; gates every state update
//   i_output_grant   per-output one-hot grant from switch_control
//   i_head / i_tail  front flit of each input is a head / tail flit
//   i_credit_return  one-cycle pulse: downstream freed a slot on output m
//   o_en             output m may accept a flit
//   o_req_mask       input n may request output m
//   o_lock_valid     output m is locked to a packet
//   o_lock_owner     one-hot lock owner per output, zero when unlocked
//   o_credit_count   current credit count per output (debug)
//   o_error          sticky protocol error per output
module output_credit_lock_ctrl #(
    parameter int unsigned N       = 5,
    parameter int unsigned M       = 5,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic [0:M-1][0:N-1]      i_output_grant,
    input  logic [0:N-1]             i_head,
    input  logic [0:N-1]             i_tail,
    input  logic [0:M-1]             i_credit_return,
    output logic [0:M-1]             o_en,
    output logic [0:N-1][0:M-1]      o_req_mask,
    output logic [0:M-1]             o_lock_valid,
    output logic [0:M-1][0:N-1]      o_lock_owner,
    output logic [0:M-1][CW-1:0]     o_credit_count,
    output logic [0:M-1]             o_error
);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e             state_q [M];
    lock_state_e             state_d [M];
    logic [0:M-1][0:N-1]     owner_q, owner_d;
    logic [0:M-1][CW-1:0]    count_q, count_d;
    logic [0:M-1]            error_q, error_d;

    // Per-output grant decode
    logic [0:M-1] grant_any;
    logic [0:M-1] grant_multi;
    logic [0:M-1] grant_head;
    logic [0:M-1] grant_tail;
    logic [0:M-1] grant_is_owner;

    for (genvar gm = 0; gm < M; gm++) begin : g_out
        assign grant_any[gm]      = |i_output_grant[gm];
        // x & (x-1) is nonzero exactly when more than one bit is set
        assign grant_multi[gm]    = |(i_output_grant[gm] & (i_output_grant[gm] - N'(1)));
        assign grant_head[gm]     = |(i_output_grant[gm] & i_head);
        assign grant_tail[gm]     = |(i_output_grant[gm] & i_tail);
        assign grant_is_owner[gm] = (i_output_grant[gm] == owner_q[gm]);

        assign o_lock_valid[gm]   = (state_q[gm] == LK_LOCKED);
`ifdef CREDIT_BYPASS_EN
        assign o_en[gm]           = (count_q[gm] != '0) | i_credit_return[gm];
`else
        assign o_en[gm]           = (count_q[gm] != '0);
`endif

        for (genvar gn = 0; gn < N; gn++) begin : g_in
            assign o_req_mask[gn][gm] = ~o_lock_valid[gm] | owner_q[gm][gn];
        end
    end

    assign o_lock_owner   = owner_q;
    assign o_credit_count = count_q;
    assign o_error        = error_q;

    // Next-state: credit counters, lock FSMs and sticky error flags
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        count_d = count_q;
        error_d = error_q;

        if (ce) begin
            for (int m = 0; m < M; m++) begin
                // Credit counter; a grant and a return in one cycle cancel out
                if (grant_any[m] && !i_credit_return[m]) begin
                    if (count_q[m] == '0) begin
                        error_d[m] = 1'b1;
                    end else begin
                        count_d[m] = count_q[m] - CW'(1);
                    end
                end else if (i_credit_return[m] && !grant_any[m]) begin
                    if (count_q[m] == CREDIT_MAX) begin
                        error_d[m] = 1'b1;
                    end else begin
                        count_d[m] = count_q[m] + CW'(1);
                    end
                end

                // Lock FSM; a malformed multi-bit grant leaves it untouched
                if (grant_multi[m]) begin
                    error_d[m] = 1'b1;
                end else if (grant_any[m]) begin
                    case (state_q[m])
                        LK_IDLE: begin
                            if (!grant_head[m]) begin
                                error_d[m] = 1'b1;
                            end else if (!grant_tail[m]) begin
                                state_d[m] = LK_LOCKED;
                                owner_d[m] = i_output_grant[m];
                            end
                        end
                        LK_LOCKED: begin
                            if (!grant_is_owner[m]) begin
                                error_d[m] = 1'b1;
                            end else if (grant_tail[m]) begin
                                state_d[m] = LK_IDLE;
                                owner_d[m] = '0;
                            end
                        end
                        default: begin
                            state_d[m] = LK_IDLE;
                            owner_d[m] = '0;
                        end
                    endcase
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < M; m++) begin
                state_q[m] <= LK_IDLE;
            end
            owner_q <= '0;
            count_q <= {M{CREDIT_MAX}};
            error_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_output_credit_lock_ctrl.sv
// Testbench for output_credit_lock_ctrl: directed scenarios followed by
// randomized traffic, checked against a per-output credit/owner model.
module tb_output_credit_lock_ctrl;

    localparam int unsigned N       = 5;
    localparam int unsigned M       = 5;
    localparam int unsigned CREDITS = 4;
    localparam int unsigned CW      = 3;

    localparam logic [0:M-1][CW-1:0] ALL_CRED = {M{CW'(CREDITS)}};

    logic                     clk;
    logic                     reset_n;
    logic                     ce;
    logic [0:M-1][0:N-1]      g_drv;
    logic [0:N-1]             h_drv;
    logic [0:N-1]             t_drv;
    logic [0:M-1]             r_drv;
    logic [0:M-1]             o_en;
    logic [0:N-1][0:M-1]      o_req_mask;
    logic [0:M-1]             o_lock_valid;
    logic [0:M-1][0:N-1]      o_lock_owner;
    logic [0:M-1][CW-1:0]     o_credit_count;
    logic [0:M-1]             o_error;

    output_credit_lock_ctrl #(
        .N(N), .M(M), .CREDITS(CREDITS), .CW(CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ce              (ce),
        .i_output_grant  (g_drv),
        .i_head          (h_drv),
        .i_tail          (t_drv),
        .i_credit_return (r_drv),
        .o_en            (o_en),
        .o_req_mask      (o_req_mask),
        .o_lock_valid    (o_lock_valid),
        .o_lock_owner    (o_lock_owner),
        .o_credit_count  (o_credit_count),
        .o_error         (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer credits, owner index (-1 = unlocked), error bit
    int cnt [M];
    int own [M];
    bit err [M];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            cnt[m] = CREDITS;
            own[m] = -1;
            err[m] = 1'b0;
        end
    endtask

    task automatic model_clock();
        if (!ce) return;
        for (int m = 0; m < M; m++) begin
            int k;
            int idx;
            k   = $countones(g_drv[m]);
            idx = -1;
            for (int n = 0; n < N; n++) if (g_drv[m][n]) idx = n;
            if (k > 0 && !r_drv[m]) begin
                if (cnt[m] == 0) err[m] = 1'b1;
                else cnt[m] = cnt[m] - 1;
            end else if (r_drv[m] && k == 0) begin
                if (cnt[m] == CREDITS) err[m] = 1'b1;
                else cnt[m] = cnt[m] + 1;
            end
            if (k > 1) begin
                err[m] = 1'b1;
            end else if (k == 1) begin
                if (own[m] < 0) begin
                    if (!h_drv[idx]) err[m] = 1'b1;
                    else if (!t_drv[idx]) own[m] = idx;
                end else if (idx == own[m]) begin
                    if (t_drv[idx]) own[m] = -1;
                end else begin
                    err[m] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [0:M-1]         e_en, e_lv, e_err;
        logic [0:N-1][0:M-1]  e_mask;
        logic [0:M-1][0:N-1]  e_own;
        logic [0:M-1][CW-1:0] e_cnt;
        for (int m = 0; m < M; m++) begin
`ifdef CREDIT_BYPASS_EN
            e_en[m] = (cnt[m] != 0) || r_drv[m];
`else
            e_en[m] = (cnt[m] != 0);
`endif
            e_lv[m]  = (own[m] >= 0);
            e_err[m] = err[m];
            e_cnt[m] = CW'(cnt[m]);
            for (int n = 0; n < N; n++) begin
                e_own[m][n]  = (own[m] == n);
                e_mask[n][m] = (own[m] < 0) || (own[m] == n);
            end
        end
        check({tag, ".en"},    64'(o_en),           64'(e_en));
        check({tag, ".mask"},  64'(o_req_mask),     64'(e_mask));
        check({tag, ".lv"},    64'(o_lock_valid),   64'(e_lv));
        check({tag, ".owner"}, 64'(o_lock_owner),   64'(e_own));
        check({tag, ".cnt"},   64'(o_credit_count), 64'(e_cnt));
        check({tag, ".err"},   64'(o_error),        64'(e_err));
    endtask

    function automatic logic [0:M-1][0:N-1] gnt1(input int m, input int n);
        logic [0:M-1][0:N-1] v;
        v = '0;
        v[m][n] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:N-1] bitn(input int n);
        logic [0:N-1] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:M-1] ret1(input int m);
        logic [0:M-1] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    // One clock: drive inputs, advance model at the edge, compare 1ns later
    task automatic cyc(input string tag, input logic [0:M-1][0:N-1] g,
                       input logic [0:N-1] h, input logic [0:N-1] t,
                       input logic [0:M-1] r, input logic c);
        g_drv = g;
        h_drv = h;
        t_drv = t;
        r_drv = r;
        ce    = c;
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, '0, '0, '0, '0, 1'b1);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".lv_async"},  64'(o_lock_valid),   64'(0));
        check({tag, ".cnt_async"}, 64'(o_credit_count), 64'(ALL_CRED));
        check_all(tag);
        g_drv = '0; h_drv = '0; t_drv = '0; r_drv = '0; ce = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        ce = 1'b1;
        g_drv = '0; h_drv = '0; t_drv = '0; r_drv = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.cnt_all4", 64'(o_credit_count), 64'(ALL_CRED));
        reset_n = 1'b1;
        repeat (3) idle("idle");
        check("idle.en_all1", 64'(o_en), 64'({M{1'b1}}));

        // Single-flit packets drain output 0 to zero credits
        repeat (4) cyc("single", gnt1(0, 1), bitn(1), bitn(1), '0, 1'b1);
        check("single.cnt0_zero", 64'(o_credit_count[0]), 64'(0));
        check("single.en0_low",   64'(o_en[0]),           64'(0));
        cyc("ret0", '0, '0, '0, ret1(0), 1'b1);
        check("ret0.cnt0_one", 64'(o_credit_count[0]), 64'(1));
        check("ret0.en0_high", 64'(o_en[0]),           64'(1));

        // Wormhole packet from input 2 on output 3
        cyc("head", gnt1(3, 2), bitn(2), '0, '0, 1'b1);
        check("head.owner3", 64'(o_lock_owner[3]), 64'(5'b00100));
        repeat (2) cyc("body", gnt1(3, 2), '0, '0, '0, 1'b1);
        check("body.lv3", 64'(o_lock_valid[3]), 64'(1));
        cyc("tail", gnt1(3, 2), '0, bitn(2), '0, 1'b1);
        check("tail.lv3", 64'(o_lock_valid[3]), 64'(0));

        // Grant and return together on output 1 at count 2
        repeat (2) cyc("out1", gnt1(1, 0), bitn(0), bitn(0), '0, 1'b1);
        cyc("both", gnt1(1, 0), bitn(0), bitn(0), ret1(1), 1'b1);
        check("both.cnt1", 64'(o_credit_count[1]), 64'(2));
        check("both.err1", 64'(o_error[1]),        64'(0));

        // Underflow on output 4, overflow on output 2
        repeat (5) cyc("under", gnt1(4, 3), bitn(3), bitn(3), '0, 1'b1);
        check("under.err4", 64'(o_error[4]),        64'(1));
        check("under.cnt4", 64'(o_credit_count[4]), 64'(0));
        idle("sticky");
        check("sticky.err4", 64'(o_error[4]), 64'(1));
        cyc("over", '0, '0, '0, ret1(2), 1'b1);
        check("over.err2", 64'(o_error[2]),        64'(1));
        check("over.cnt2", 64'(o_credit_count[2]), 64'(4));

        // ce low holds all state
        repeat (5) cyc("ce_low", gnt1(2, 0), bitn(0), '0, ret1(0), 1'b0);
        check("ce_low.lv2", 64'(o_lock_valid[2]), 64'(0));

        // Reset in the middle of a packet
        cyc("mid_head", gnt1(2, 0), bitn(0), '0, '0, 1'b1);
        cyc("mid_body", gnt1(2, 0), '0, '0, '0, 1'b1);
        async_reset("mid_rst");
        idle("post_rst");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [0:M-1][0:N-1] g;
            logic [0:M-1]        r;
            g = '0;
            for (int m = 0; m < M; m++) begin
                int sel;
                int a;
                int b;
                sel = int'($urandom_range(0, 9));
                a   = int'($urandom_range(0, N - 1));
                b   = (a + 1 + int'($urandom_range(0, N - 2))) % N;
                if (sel >= 5) g[m][a] = 1'b1;
                if (sel == 9) g[m][b] = 1'b1;
                r[m] = ($urandom_range(0, 9) < 4);
            end
            cyc("rand", g, N'($urandom), N'($urandom), r,
                ($urandom_range(0, 9) != 0));
            if (i % 75 == 74) async_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
